// File: rtl/combi_fetch.sv
// combi_fetch: fetch stage and IF/ID pipeline register for the dual-ISA core.
// Owns the fetch PC, issues one instruction-memory request at a time, parks a
// response in a one-entry hold buffer while decode is stalled, and drops
// in-flight fetches that a taken redirect has made stale.
module combi_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_RV   = 32'h0000_0013,
    parameter logic [31:0] NOP_ARM  = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] PCPlus8D,
    output logic        ArmD,
    output logic        ValidD
);

    // ISSUE: request on the bus. WAIT: response pending, still wanted.
    // HOLD:  response parked in the buffer until decode accepts it.
    // KILL:  response pending but stale; it is swallowed when it arrives.
    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    // PC arithmetic is plain modulo-2^32; wrapping past the top is legal.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

    // Bubble encoding depends on which ISA the decoder is currently in.
    function automatic logic [31:0] nop_for(input logic is_arm);
        return is_arm ? NOP_ARM : NOP_RV;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;

    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        hold_arm_q, hold_arm_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic        armd_q, armd_d;
    logic        validd_q, validd_d;

    // Instruction handed to IF/ID this cycle (from the bus or the hold buffer).
    logic        deliver;
    logic [31:0] dlv_instr;
    logic [31:0] dlv_pc;
    logic        dlv_arm;

    // Fetch FSM: next state, next PC, hold-buffer capture and delivery select.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_arm_d   = hold_arm_q;
        deliver      = 1'b0;
        dlv_instr    = ImemRdata;
        dlv_pc       = pcf_q;
        dlv_arm      = arm;

        case (state_q)
            S_ISSUE: begin
                // The request goes out regardless; a redirect can only mark it stale.
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = S_KILL;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (PCSrcE) begin
                    // A coincident response is consumed here, so only wait
                    // for the stale one if it has not arrived yet.
                    pcf_d   = PCTargetE;
                    state_d = ImemValid ? S_ISSUE : S_KILL;
                end else if (ImemValid && !StallD) begin
                    deliver   = 1'b1;
                    dlv_instr = ImemRdata;
                    dlv_pc    = pcf_q;
                    dlv_arm   = arm;
                    pcf_d     = pc_inc(pcf_q, 32'd4);
                    state_d   = S_ISSUE;
                end else if (ImemValid) begin
                    hold_instr_d = ImemRdata;
                    hold_pc_d    = pcf_q;
                    hold_arm_d   = arm;
                    state_d      = S_HOLD;
                end
            end

            S_HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = S_ISSUE;
                end else if (!StallD) begin
                    deliver   = 1'b1;
                    dlv_instr = hold_instr_q;
                    dlv_pc    = hold_pc_q;
                    dlv_arm   = hold_arm_q;
                    pcf_d     = pc_inc(pcf_q, 32'd4);
                    state_d   = S_ISSUE;
                end
            end

            S_KILL: begin
                // Keep tracking redirects until the stale response drains.
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                end
                if (ImemValid) begin
                    state_d = S_ISSUE;
                end
            end

            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    // IF/ID next value: flush beats stall, stall beats load, otherwise bubble.
    always_comb begin
        instr_d  = instr_q;
        pcd_d    = pcd_q;
        armd_d   = armd_q;
        validd_d = validd_q;

        if (FlushD) begin
            validd_d = 1'b0;
            instr_d  = nop_for(armd_q);
        end else if (StallD) begin
            validd_d = validd_q;
        end else if (deliver) begin
            validd_d = 1'b1;
            instr_d  = dlv_instr;
            pcd_d    = dlv_pc;
            armd_d   = dlv_arm;
        end else begin
            validd_d = 1'b0;
        end
    end

    // Fetch control and IF/ID register; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_ISSUE;
            pcf_q    <= RESET_PC;
            instr_q  <= NOP_RV;
            pcd_q    <= 32'h0000_0000;
            armd_q   <= 1'b0;
            validd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            armd_q   <= armd_d;
            validd_q <= validd_d;
        end
    end

    // Hold buffer payload; only meaningful while in HOLD, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_instr_q <= hold_instr_d;
        hold_pc_q    <= hold_pc_d;
        hold_arm_q   <= hold_arm_d;
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the memory side broke protocol.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(ImemValid && (state_q != S_WAIT) && (state_q != S_KILL)))
            else $error("combi_fetch: ImemValid with no outstanding request");
        end
    end
`endif

    assign ImemReq  = (state_q == S_ISSUE) && !reset;
    assign ImemAddr = pcf_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc_inc(pcd_q, 32'd4);
    assign PCPlus8D = pc_inc(pcd_q, 32'd8);
    assign ArmD     = armd_q;
    assign ValidD   = validd_q;

endmodule

// File: tb/tb_combi_fetch.sv
// Bench for combi_fetch: a directed cycle table for the documented corner
// cases, then a randomized run against a transaction-level fetch model.
module tb_combi_fetch;

    localparam logic [31:0] RPC     = 32'h0000_0100;
    localparam logic [31:0] NOP_RV  = 32'h0000_0013;
    localparam logic [31:0] NOP_ARM = 32'hE1A0_0000;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] PCPlus8D;
    logic        ArmD;
    logic        ValidD;

    combi_fetch #(
        .RESET_PC (RPC),
        .NOP_RV   (NOP_RV),
        .NOP_ARM  (NOP_ARM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemValid (ImemValid),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .PCPlus8D  (PCPlus8D),
        .ArmD      (ArmD),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Memory contents: any fixed address-dependent pattern will do.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // lvl: 0 = check ValidD only, 1 = also InstrD, 2 = full IF/ID contents.
    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        iv;
        logic [31:0] rdata;
        logic        arm;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        int          lvl;
        logic [31:0] e_instr;
        logic [31:0] e_pcd;
        logic        e_armd;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic p, input logic [31:0] t,
                                input logic v, input logic [31:0] d, input logic a,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input int l, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ed);
        vec_t r;
        r.stall = s; r.flush = f; r.pcsrc = p; r.tgt = t; r.iv = v; r.rdata = d; r.arm = a;
        r.e_req = er; r.e_addr = ea; r.e_vld = ev; r.lvl = l; r.e_instr = ei; r.e_pcd = ep;
        r.e_armd = ed;
        return r;
    endfunction

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    // Random-phase model state.
    logic        outstanding;
    int          wait_cnt;
    logic [31:0] out_addr;
    logic [31:0] exp_next_pc;
    logic        resp_arm;
    logic        m_vld;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_armd;
    int          deliveries;

    initial begin
        // Cycle-by-cycle table; each row is driven at a falling edge.
        tbl[0]  = mk(N,N,N,32'h0,N,32'h0,N,         Y,32'h100,      N,0,32'h0,32'h0,N);
        tbl[1]  = mk(N,N,N,32'h0,Y,32'hA000_0100,N, N,32'h0,        Y,2,32'hA000_0100,32'h100,N);
        tbl[2]  = mk(N,N,N,32'h0,N,32'h0,N,         Y,32'h104,      N,0,32'h0,32'h0,N);
        tbl[3]  = mk(N,N,N,32'h0,Y,32'hA000_0104,N, N,32'h0,        Y,2,32'hA000_0104,32'h104,N);
        tbl[4]  = mk(N,N,N,32'h0,N,32'h0,N,         Y,32'h108,      N,0,32'h0,32'h0,N);
        tbl[5]  = mk(Y,N,N,32'h0,Y,32'hA000_0108,N, N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[6]  = mk(Y,N,N,32'h0,N,32'h0,N,         N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[7]  = mk(Y,N,N,32'h0,N,32'h0,N,         N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[8]  = mk(Y,N,N,32'h0,N,32'h0,N,         N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[9]  = mk(N,N,N,32'h0,N,32'h0,N,         N,32'h0,        Y,2,32'hA000_0108,32'h108,N);
        tbl[10] = mk(N,N,N,32'h0,N,32'h0,N,         Y,32'h10C,      N,0,32'h0,32'h0,N);
        tbl[11] = mk(N,N,Y,32'h200,N,32'h0,N,       N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[12] = mk(N,N,N,32'h0,Y,32'hDEAD_BEEF,N, N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[13] = mk(N,N,N,32'h0,N,32'h0,N,         Y,32'h200,      N,0,32'h0,32'h0,N);
        tbl[14] = mk(Y,Y,Y,32'h300,Y,32'hA000_0200,N, N,32'h0,      N,1,NOP_RV,32'h0,N);
        tbl[15] = mk(N,N,N,32'h0,N,32'h0,N,         Y,32'h300,      N,0,32'h0,32'h0,N);
        tbl[16] = mk(N,N,Y,32'hFFFF_FFFC,N,32'h0,Y, N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[17] = mk(N,N,N,32'h0,Y,32'h0BAD_F00D,Y, N,32'h0,        N,0,32'h0,32'h0,N);
        tbl[18] = mk(N,N,N,32'h0,N,32'h0,Y,         Y,32'hFFFF_FFFC,N,0,32'h0,32'h0,N);
        tbl[19] = mk(N,N,N,32'h0,Y,32'hE3A0_1001,Y, N,32'h0,        Y,2,32'hE3A0_1001,32'hFFFF_FFFC,Y);
        tbl[20] = mk(N,N,N,32'h0,N,32'h0,Y,         Y,32'h0,        N,0,32'h0,32'h0,N);
        tbl[21] = mk(N,Y,N,32'h0,N,32'h0,Y,         N,32'h0,        N,1,NOP_ARM,32'h0,N);
        tbl[22] = mk(N,N,N,32'h0,Y,32'hE1A0_1002,Y, N,32'h0,        Y,2,32'hE1A0_1002,32'h0,Y);
        tbl[23] = mk(N,N,N,32'h0,N,32'h0,Y,         Y,32'h4,        N,0,32'h0,32'h0,N);

        reset = 1'b1; arm = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; ImemValid = 1'b0; ImemRdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk1 ("reset ImemReq",  ImemReq,  1'b0);
        chk1 ("reset ValidD",   ValidD,   1'b0);
        chk32("reset InstrD",   InstrD,   NOP_RV);
        chk32("reset PCD",      PCD,      32'h0);
        chk32("reset PCPlus4D", PCPlus4D, 32'h4);
        chk32("reset PCPlus8D", PCPlus8D, 32'h8);
        chk1 ("reset ArmD",     ArmD,     1'b0);
        chk32("reset ImemAddr", ImemAddr, RPC);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            StallD = tbl[i].stall; FlushD = tbl[i].flush; PCSrcE = tbl[i].pcsrc;
            PCTargetE = tbl[i].tgt; ImemValid = tbl[i].iv; ImemRdata = tbl[i].rdata;
            arm = tbl[i].arm;
            #1;
            chk1($sformatf("row%0d ImemReq", i), ImemReq, tbl[i].e_req);
            if (tbl[i].e_req)
                chk32($sformatf("row%0d ImemAddr", i), ImemAddr, tbl[i].e_addr);
            @(posedge clk);
            #1;
            chk1($sformatf("row%0d ValidD", i), ValidD, tbl[i].e_vld);
            if (tbl[i].lvl >= 1)
                chk32($sformatf("row%0d InstrD", i), InstrD, tbl[i].e_instr);
            if (tbl[i].lvl >= 2) begin
                chk32($sformatf("row%0d PCD", i), PCD, tbl[i].e_pcd);
                chk32($sformatf("row%0d PCPlus4D", i), PCPlus4D, tbl[i].e_pcd + 32'd4);
                chk32($sformatf("row%0d PCPlus8D", i), PCPlus8D, tbl[i].e_pcd + 32'd8);
                chk1 ($sformatf("row%0d ArmD", i), ArmD, tbl[i].e_armd);
            end
            @(negedge clk);
        end

        // Reset while the fetch of address 4 is outstanding: request is abandoned.
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; ImemValid = 1'b0; arm = 1'b0;
        reset = 1'b1;
        #1;
        chk1 ("midreset ImemReq", ImemReq, 1'b0);
        chk1 ("midreset ValidD",  ValidD,  1'b0);
        chk32("midreset InstrD",  InstrD,  NOP_RV);
        chk32("midreset PCD",     PCD,     32'h0);
        chk1 ("midreset ArmD",    ArmD,    1'b0);
        @(posedge clk);
        #1;
        chk1("midreset ImemReq held", ImemReq, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized run: memory with 1..4 cycle latency, random stalls and redirects.
        outstanding = 1'b0; wait_cnt = 0; out_addr = 32'h0; exp_next_pc = RPC;
        resp_arm = 1'b0; m_vld = 1'b0; m_instr = NOP_RV; m_pcd = 32'h0; m_armd = 1'b0;
        deliveries = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        req_seen;
            logic [31:0] addr_seen;
            if (outstanding) wait_cnt--;
            ImemValid = outstanding && (wait_cnt == 0);
            ImemRdata = ImemValid ? mem_word(out_addr) : $urandom;
            StallD    = ($urandom_range(0, 3) == 0);
            PCSrcE    = ($urandom_range(0, 19) == 0);
            PCTargetE = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            FlushD    = PCSrcE && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) arm = ~arm;
            if (ImemValid) resp_arm = arm;
            #1;
            req_seen  = ImemReq;
            addr_seen = ImemAddr;
            if (req_seen) begin
                chk1 ("rand req while outstanding", outstanding, 1'b0);
                chk32("rand ImemAddr", addr_seen, exp_next_pc);
            end
            @(posedge clk);
            #1;
            if (ImemValid) outstanding = 1'b0;
            if (req_seen) begin
                outstanding = 1'b1;
                out_addr    = addr_seen;
                wait_cnt    = int'($urandom_range(1, 4));
            end
            if (FlushD) begin
                chk1 ("rand flush ValidD", ValidD, 1'b0);
                chk32("rand flush InstrD", InstrD, m_armd ? NOP_ARM : NOP_RV);
                m_vld   = 1'b0;
                m_instr = m_armd ? NOP_ARM : NOP_RV;
            end else if (StallD) begin
                chk1("rand stall ValidD", ValidD, m_vld);
                if (m_vld) begin
                    chk32("rand stall InstrD", InstrD, m_instr);
                    chk32("rand stall PCD", PCD, m_pcd);
                    chk1 ("rand stall ArmD", ArmD, m_armd);
                end
            end else if (ValidD) begin
                chk32("rand PCD", PCD, exp_next_pc);
                chk32("rand InstrD", InstrD, mem_word(exp_next_pc));
                chk32("rand PCPlus4D", PCPlus4D, exp_next_pc + 32'd4);
                chk32("rand PCPlus8D", PCPlus8D, exp_next_pc + 32'd8);
                chk1 ("rand ArmD", ArmD, resp_arm);
                m_vld = 1'b1; m_instr = mem_word(exp_next_pc); m_pcd = exp_next_pc;
                m_armd = resp_arm;
                exp_next_pc = exp_next_pc + 32'd4;
                deliveries++;
            end else begin
                m_vld = 1'b0;
            end
            if (PCSrcE) exp_next_pc = PCTargetE;
            @(negedge clk);
        end

        checks++;
        if (deliveries < 200) begin
            errors++;
            $display("FAIL rand throughput actual=%0d required>=%0d", deliveries, 200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
